// File: rtl/disp_scan_n.sv
// Time-multiplexed common-anode seven-segment driver: scans DIGITS hex digits MSB first,
// with frame snapshots, per-digit decimal points, blinking and leading-zero blanking.
module disp_scan_n #(
  parameter int DIGITS       = 4,
  parameter int SCAN_TICKS   = 131072,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_blank,
  output logic [DIGITS-1:0]     enable,
  output logic [7:0]            segment,
  output logic                  frame_start
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_TICKS);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(SCAN_TICKS - 1);
  localparam logic [FRM_W-1:0] FRM_MAX  = FRM_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0]    preCount_q,   preCount_d;
  logic [IDX_W-1:0]    digitIdx_q,   digitIdx_d;
  logic [FRM_W-1:0]    frameCnt_q,   frameCnt_d;
  logic                blinkPhase_q, blinkPhase_d;
  logic [4*DIGITS-1:0] shNumber_q,   shNumber_d;
  logic [DIGITS-1:0]   shDp_q,       shDp_d;
  logic [DIGITS-1:0]   shBlink_q,    shBlink_d;
  logic                shLzBlank_q,  shLzBlank_d;
  logic                shPhase_q,    shPhase_d;
  logic [DIGITS-1:0]   enable_q,     enable_d;
  logic [7:0]          segment_q,    segment_d;

  logic                tick;
  logic                snapshot;
  logic [DIGITS-1:0]   selOneHot;
  logic [3:0]          selNib;
  logic                selDp;
  logic                selBlink;
  logic                selLead;
  logic [DIGITS-1:0]   slotEn;
  logic [7:0]          slotSeg;

  // Active-low segment pattern (a..g in bits 0..6) for one hex nibble.
  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s[6:0];
  endfunction

  // Scan timing: prescaler, digit index and the blink frame counter.
  always_comb begin
    tick         = (preCount_q == PRE_MAX);
    snapshot     = tick && (digitIdx_q == '0);
    preCount_d   = tick ? '0 : preCount_q + 1'b1;
    digitIdx_d   = digitIdx_q;
    frameCnt_d   = frameCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (tick) begin
      digitIdx_d = (digitIdx_q == '0) ? LAST_IDX : digitIdx_q - 1'b1;
    end
    if (snapshot) begin
      if (frameCnt_q == FRM_MAX) begin
        frameCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        frameCnt_d = frameCnt_q + 1'b1;
      end
    end
  end

  // The frame's blink phase is the value before this snapshot's update, so the
  // first BLINK_FRAMES frames after reset are visible.
  always_comb begin
    shNumber_d  = snapshot ? number       : shNumber_q;
    shDp_d      = snapshot ? dp           : shDp_q;
    shBlink_d   = snapshot ? blink        : shBlink_q;
    shLzBlank_d = snapshot ? lz_blank     : shLzBlank_q;
    shPhase_d   = snapshot ? blinkPhase_q : shPhase_q;
  end

  // Next slot's drive, built from the post-tick index and shadows so the outputs
  // change on the edge that ends the tick cycle.
  always_comb begin
    selOneHot = '0;
    selNib    = '0;
    selDp     = 1'b0;
    selBlink  = 1'b0;
    selLead   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digitIdx_d == IDX_W'(k)) begin
        selOneHot[k] = 1'b1;
        selNib       = shNumber_d[4*k +: 4];
        selDp        = shDp_d[k];
        selBlink     = shBlink_d[k];
        selLead      = (k != 0) && ((shNumber_d >> (4*k)) == '0);
      end
    end
    slotEn  = '1;
    slotSeg = 8'hFF;
    if (!(selBlink && shPhase_d)) begin
      slotEn  = ~selOneHot;
      slotSeg = {~selDp, (shLzBlank_d && selLead) ? 7'h7F : hexToSeg(selNib)};
    end
    enable_d  = tick ? slotEn  : enable_q;
    segment_d = tick ? slotSeg : segment_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      preCount_q   <= '0;
      digitIdx_q   <= '0;
      frameCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      shNumber_q   <= '0;
      shDp_q       <= '0;
      shBlink_q    <= '0;
      shLzBlank_q  <= 1'b0;
      shPhase_q    <= 1'b0;
      enable_q     <= '1;
      segment_q    <= 8'hFF;
    end else begin
      preCount_q   <= preCount_d;
      digitIdx_q   <= digitIdx_d;
      frameCnt_q   <= frameCnt_d;
      blinkPhase_q <= blinkPhase_d;
      shNumber_q   <= shNumber_d;
      shDp_q       <= shDp_d;
      shBlink_q    <= shBlink_d;
      shLzBlank_q  <= shLzBlank_d;
      shPhase_q    <= shPhase_d;
      enable_q     <= enable_d;
      segment_q    <= segment_d;
    end
  end

  assign enable      = enable_q;
  assign segment     = segment_q;
  assign frame_start = snapshot;

endmodule

// File: tb/tb_disp_scan_n.sv
// Bench for disp_scan_n: cycle-level arithmetic model checked every cycle, plus
// hand-computed expectations at chosen cycles of each scenario.
module tb_disp_scan_n;

  localparam int DIGITS       = 4;
  localparam int SCAN_TICKS   = 4;
  localparam int BLINK_FRAMES = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [4*DIGITS-1:0] number;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blink;
  logic                lz_blank;
  logic [DIGITS-1:0]   enable;
  logic [7:0]          segment;
  logic                frame_start;

  int checks = 0;
  int errors = 0;
  int curCycle = 0;

  disp_scan_n #(
    .DIGITS(DIGITS),
    .SCAN_TICKS(SCAN_TICKS),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .number(number),
    .dp(dp),
    .blink(blink),
    .lz_blank(lz_blank),
    .enable(enable),
    .segment(segment),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Model state: cycles since the last reset edge and the inputs captured at the last frame start.
  logic [7:0]          segTable [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  bit                  modelValid = 1'b0;
  int                  mCyc = 0;
  logic [4*DIGITS-1:0] snapNum;
  logic [DIGITS-1:0]   snapDp;
  logic [DIGITS-1:0]   snapBlink;
  logic                snapLz;

  always @(posedge clk) begin
    if (!rst_n) begin
      modelValid = 1'b1;
      mCyc       = 0;
      snapNum    = '0;
      snapDp     = '0;
      snapBlink  = '0;
      snapLz     = 1'b0;
    end else if (modelValid) begin
      if ((mCyc % SCAN_TICKS == SCAN_TICKS - 1) && ((mCyc / SCAN_TICKS) % DIGITS == 0)) begin
        snapNum   = number;
        snapDp    = dp;
        snapBlink = blink;
        snapLz    = lz_blank;
      end
      mCyc++;
    end
  end

  always @(negedge clk) begin
    logic [DIGITS-1:0] expEn;
    logic [7:0]        expSeg;
    logic              expFs;
    logic [3:0]        nib;
    int slot, d, f;
    if (modelValid) begin
      expEn  = '1;
      expSeg = 8'hFF;
      expFs  = (mCyc % SCAN_TICKS == SCAN_TICKS - 1) && ((mCyc / SCAN_TICKS) % DIGITS == 0);
      if (mCyc >= SCAN_TICKS) begin
        slot = mCyc / SCAN_TICKS - 1;
        d    = DIGITS - 1 - (slot % DIGITS);
        f    = slot / DIGITS;
        if (!(snapBlink[d] && ((f / BLINK_FRAMES) % 2 == 1))) begin
          nib    = 4'(snapNum >> (4 * d));
          expEn  = ~(DIGITS'(1) << d);
          expSeg = {~snapDp[d], segTable[nib][6:0]};
          if (snapLz && d != 0 && ((snapNum >> (4 * d)) == '0)) expSeg[6:0] = 7'h7F;
        end
      end
      checks++;
      if (enable !== expEn) begin
        errors++;
        $display("[TB] FAIL model.enable t=%0t: got %b want %b", $time, enable, expEn);
      end
      checks++;
      if (segment !== expSeg) begin
        errors++;
        $display("[TB] FAIL model.segment t=%0t: got %h want %h", $time, segment, expSeg);
      end
      checks++;
      if (frame_start !== expFs) begin
        errors++;
        $display("[TB] FAIL model.frame_start t=%0t: got %b want %b", $time, frame_start, expFs);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] numV, input logic [3:0] dpV,
                               input logic [3:0] blinkV, input logic lzV);
    number   = numV;
    dp       = dpV;
    blink    = blinkV;
    lz_blank = lzV;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expEn,
                             input logic [7:0] expSeg, input logic expFs);
    checks++;
    if (enable !== expEn || segment !== expSeg || frame_start !== expFs) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d: got en=%b seg=%h fs=%b want en=%b seg=%h fs=%b",
               name, curCycle, enable, segment, frame_start, expEn, expSeg, expFs);
    end
  endtask

  task automatic stepTo(input int target);
    while (curCycle < target) begin
      @(negedge clk);
      curCycle++;
    end
  endtask

  task automatic checkAt(input int cyc, input string name, input logic [3:0] expEn,
                         input logic [7:0] expSeg, input logic expFs);
    stepTo(cyc);
    checkOutput(name, expEn, expSeg, expFs);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(16'h12AF, 4'b0100, 4'b0000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    curCycle = 0;
    $display("[TB] reset release and basic scan");
    checkAt(0,  "rstBlank0", 4'hF, 8'hFF, 1'b0);
    checkAt(1,  "rstBlank1", 4'hF, 8'hFF, 1'b0);
    checkAt(2,  "rstBlank2", 4'hF, 8'hFF, 1'b0);
    checkAt(3,  "firstFs",   4'hF, 8'hFF, 1'b1);
    checkAt(4,  "scanD3",    4'b0111, 8'hF9, 1'b0);
    checkAt(8,  "scanD2",    4'b1011, 8'h24, 1'b0);
    checkAt(12, "scanD1",    4'b1101, 8'h88, 1'b0);
    checkAt(16, "scanD0",    4'b1110, 8'h8E, 1'b0);
    checkAt(19, "secondFs",  4'b1110, 8'h8E, 1'b1);
    checkAt(20, "scanRepeat", 4'b0111, 8'hF9, 1'b0);

    $display("[TB] leading-zero blanking");
    applyStimulus(16'h0005, 4'b0000, 4'b0000, 1'b1);
    checkAt(36, "lzD3", 4'b0111, 8'hFF, 1'b0);
    checkAt(40, "lzD2", 4'b1011, 8'hFF, 1'b0);
    checkAt(44, "lzD1", 4'b1101, 8'hFF, 1'b0);
    checkAt(48, "lzD0", 4'b1110, 8'h92, 1'b0);
    applyStimulus(16'h0000, 4'b0000, 4'b0000, 1'b1);
    checkAt(60, "lzZeroD1", 4'b1101, 8'hFF, 1'b0);
    checkAt(64, "lzZeroD0", 4'b1110, 8'hC0, 1'b0);

    $display("[TB] snapshot isolation");
    applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
    checkAt(72, "snapD2", 4'b1011, 8'hF9, 1'b0);
    stepTo(73);
    applyStimulus(16'h2222, 4'b0000, 4'b0000, 1'b0);
    checkAt(76, "snapHoldD1", 4'b1101, 8'hF9, 1'b0);
    checkAt(80, "snapHoldD0", 4'b1110, 8'hF9, 1'b0);
    checkAt(84, "snapNewD3",  4'b0111, 8'hA4, 1'b0);
    checkAt(96, "snapNewD0",  4'b1110, 8'hA4, 1'b0);

    $display("[TB] mid-scan reset, then blink");
    stepTo(105);
    applyStimulus(16'h1234, 4'b0000, 4'b0001, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    curCycle = 0;
    checkOutput("midRst", 4'hF, 8'hFF, 1'b0);
    checkAt(1,  "restartBlank1", 4'hF, 8'hFF, 1'b0);
    checkAt(2,  "restartBlank2", 4'hF, 8'hFF, 1'b0);
    checkAt(3,  "restartFs",     4'hF, 8'hFF, 1'b1);
    checkAt(4,  "restartD3",     4'b0111, 8'hF9, 1'b0);
    checkAt(16, "blinkF0D0",     4'b1110, 8'h99, 1'b0);
    checkAt(32, "blinkF1D0",     4'b1110, 8'h99, 1'b0);
    checkAt(36, "blinkF2D3",     4'b0111, 8'hF9, 1'b0);
    checkAt(40, "blinkF2D2",     4'b1011, 8'hA4, 1'b0);
    checkAt(44, "blinkF2D1",     4'b1101, 8'hB0, 1'b0);
    checkAt(48, "blinkF2D0off",  4'hF, 8'hFF, 1'b0);
    checkAt(64, "blinkF3D0off",  4'hF, 8'hFF, 1'b0);
    checkAt(80, "blinkF4D0",     4'b1110, 8'h99, 1'b0);
    stepTo(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_n.md
# disp_scan_n

Parametrised time-multiplexed seven-segment display driver: scans `DIGITS` hex digits onto a common-anode display with a programmable refresh rate. It adds tear-free frame snapshots, per-digit decimal points, per-digit blinking and optional leading-zero blanking. It includes its own hex-to-segment decoder and sits between the CPU debug/status registers and the board display pins.

## Interface

Parameters:
- `DIGITS`, default 4: number of digits, legal range 1..8.
- `SCAN_TICKS`, default 131072: clock cycles per digit slot, minimum 2.
- `BLINK_FRAMES`, default 32: full frames per blink half-period, minimum 1.

Ports:
- `clk` input, 1 bit: single system clock; all logic is on the rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `number` input, 4*DIGITS bits: hex value to display. Nibble i drives digit i; digit DIGITS-1 is the most significant.
- `dp` input, DIGITS bits: decimal point request per digit, 1 = lit.
- `blink` input, DIGITS bits: blink enable per digit.
- `lz_blank` input, 1 bit: 1 = suppress leading zeros.
- `enable` output, DIGITS bits: digit anode selects, active-low, one-hot-low while scanning.
- `segment` output, 8 bits: active-low segments. Bit 0 = a through bit 6 = g; bit 7 = dp.
- `frame_start` output, 1 bit: one-cycle pulse on the cycle the snapshot loads.

## Operation

- Prescaler counts 0..SCAN_TICKS-1 and wraps. `tick` is the cycle where prescaler = SCAN_TICKS-1.
- Digit index resets to 0. On each `tick`, index decrements, and 0 wraps to DIGITS-1, so scan order is MSB first.
- Snapshot: when index wraps from 0 to DIGITS-1 on a `tick`:
  - `number`, `dp`, `blink` and `lz_blank` are copied into shadow registers.
  - `frame_start` pulses that same cycle.
  - Input changes mid-frame are never displayed until the next snapshot.
- Blink: a frame counter counts `frame_start` pulses 0..BLINK_FRAMES-1. At wrap it toggles `blink_phase`, which resets to 0 (visible).
- Per-slot output for the selected digit i, taken from the shadows:
  - Blinked off (blink[i]=1 and blink_phase=1): enable = all ones, segment = 8'hFF.
  - Leading-zero blanked (lz_blank=1, i≠0, and nibbles DIGITS-1..i all zero): enable[i]=0, segment[6:0] = 7'h7F, and segment[7] = ~dp[i].
  - Otherwise: enable[i]=0, segment[6:0] = decode(nibble i), segment[7] = ~dp[i].
- Digit 0 is never leading-zero blanked.
- Decode, given as segment values with dp off: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
- `enable` and `segment` are registered and glitch-free; exactly zero or one `enable` bit is low.

## Timing

- Reset (`rst_n`=0 at a clock edge), on the next edge:
  - enable = all ones, segment = 8'hFF, frame_start = 0.
  - Prescaler, index, frame counter and blink_phase = 0; shadows = 0.
- After release, outputs stay blank until the first `tick`, which occurs SCAN_TICKS-1 cycles after the release edge. That tick loads the snapshot and selects digit DIGITS-1.
- Output latency: `enable`/`segment` reflect the new slot on the edge following `tick`, one cycle after the `frame_start` pulse.
- Slot length is exactly SCAN_TICKS cycles; frame length is DIGITS*SCAN_TICKS cycles.
- If `number` changes in the cycle a snapshot loads, the value sampled at that edge is the one captured.
- Reset asserted mid-slot or mid-blink aborts immediately; there is no partial frame completion.
- DIGITS=1: every `tick` is a frame start, and the index stays 0.

## Test plan

DIGITS=4, SCAN_TICKS=4, BLINK_FRAMES=2 unless stated.
- Reset release:
  - enable=4'hF and segment=8'hFF for 3 cycles.
  - frame_start pulses on cycle 3.
  - Cycle 4: enable=4'b0111, segment from number[15:12].
- number=16'h12AF, dp=4'b0100:
  - Sequence of (enable, segment) pairs, each held 4 cycles and repeating every 16 cycles: (0111, F9), (1011, 24), (1101, 88), (1110, 8E).
- lz_blank=1, number=16'h0005: digits 3..1 give segment=FF with their enable bit low; digit 0 gives 92. With number=16'h0000, digit 0 gives C0.
- Snapshot: change number from 16'h1111 to 16'h2222 during the digit-2 slot. Digits 1 and 0 still show F9; 2222 appears only after the next frame_start.
- Blink: blink=4'b0001, number=16'h1234. Frames 0–1 show digit 0 as 99. In frames 2–3, enable=4'hF and segment=FF during the digit-0 slot, while other digits are unaffected.
- Mid-scan reset: assert rst_n=0 during the digit-2 slot. Next edge gives enable=4'hF, segment=FF, frame_start=0. Restart timing is identical to the reset-release case.
